// File: rtl/param_fifo_if.sv
// Handshake and status bundle for param_fifo: the producer/consumer side
// drives the request signals (master) and the FIFO answers (slave).
interface param_fifo_if #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 32
);
  localparam int CW = $clog2(DEPTH + 1);

  logic             flush;
  logic             wr_en;
  logic [WIDTH-1:0] din;
  logic             rd_en;
  logic [WIDTH-1:0] dout;
  logic             dout_valid;
  logic             full;
  logic             empty;
  logic             almost_full;
  logic             almost_empty;
  logic [CW-1:0]    count;
  logic             overflow;
  logic             underflow;

  modport master (
    output flush, wr_en, din, rd_en,
    input  dout, dout_valid, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );

  modport slave (
    input  flush, wr_en, din, rd_en,
    output dout, dout_valid, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );
endinterface

// File: rtl/param_fifo.sv
// Parametrised single-clock FIFO for any DEPTH >= 2, with registered-read or
// first-word-fall-through output, almost flags, sticky error flags and flush.
module param_fifo #(
  parameter int WIDTH        = 16,
  parameter int DEPTH        = 32,
  parameter int FWFT         = 0,
  parameter int AFULL_LEVEL  = DEPTH - 2,
  parameter int AEMPTY_LEVEL = 2
) (
  input  logic        clk,
  input  logic        rst,
  param_fifo_if.slave bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count_q;
  logic [CW-1:0]    count_d;
  logic             full_int;
  logic             empty_int;
  logic             wr_acc;
  logic             rd_acc;
  logic             overflow_q;
  logic             underflow_q;

  // Explicit wrap so non-power-of-two depths never address past the last entry.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST) ? '0 : p + PW'(1);
  endfunction

  assign full_int  = (count_q == CW'(DEPTH));
  assign empty_int = (count_q == '0);
  assign wr_acc    = bus.wr_en & ~full_int  & ~bus.flush;
  assign rd_acc    = bus.rd_en & ~empty_int & ~bus.flush;

  always_comb begin
    // NOTE: count_d gets its default first so every path assigns it and no latch is inferred.
    count_d = count_q;
    if (bus.flush)
      count_d = '0;
    else if (wr_acc && !rd_acc)
      count_d = count_q + CW'(1);
    else if (rd_acc && !wr_acc)
      count_d = count_q - CW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      count_q <= count_d;
      if (bus.flush) begin
        wr_ptr      <= '0;
        rd_ptr      <= '0;
        overflow_q  <= 1'b0;
        underflow_q <= 1'b0;
      end else begin
        if (wr_acc) wr_ptr <= ptr_inc(wr_ptr);
        if (rd_acc) rd_ptr <= ptr_inc(rd_ptr);
        if (bus.wr_en && full_int)  overflow_q  <= 1'b1;
        if (bus.rd_en && empty_int) underflow_q <= 1'b1;
      end
    end
  end

  // NOTE: storage is deliberately not reset; count and pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr] <= bus.din;
  end

  generate
    if (FWFT != 0) begin : g_fwft
      assign bus.dout       = mem[rd_ptr];
      assign bus.dout_valid = ~empty_int;
    end else begin : g_reg
      logic [WIDTH-1:0] dout_q;
      logic             valid_q;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          dout_q  <= '0;
          valid_q <= 1'b0;
        end else if (bus.flush) begin
          dout_q  <= '0;
          valid_q <= 1'b0;
        end else begin
          valid_q <= rd_acc;
          if (rd_acc) dout_q <= mem[rd_ptr];
        end
      end

      assign bus.dout       = dout_q;
      assign bus.dout_valid = valid_q;
    end
  endgenerate

  assign bus.full         = full_int;
  assign bus.empty        = empty_int;
  assign bus.almost_full  = (count_q >= CW'(AFULL_LEVEL));
  assign bus.almost_empty = (count_q <= CW'(AEMPTY_LEVEL));
  assign bus.count        = count_q;
  assign bus.overflow     = overflow_q;
  assign bus.underflow    = underflow_q;
endmodule

// File: tb/tb_param_fifo.sv
// Drives one stimulus stream into a registered-read FIFO (DEPTH=5) and a
// fall-through FIFO (DEPTH=8); each is checked against its own queue model.
`timescale 1ns/1ps
module tb_param_fifo;
  localparam int W   = 16;
  localparam int DA  = 5;
  localparam int AFA = 3;
  localparam int AEA = 1;
  localparam int DB  = 8;
  localparam int AFB = 6;
  localparam int AEB = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  param_fifo_if #(.WIDTH(W), .DEPTH(DA)) bus_a ();
  param_fifo_if #(.WIDTH(W), .DEPTH(DB)) bus_b ();

  param_fifo #(.WIDTH(W), .DEPTH(DA), .FWFT(0), .AFULL_LEVEL(AFA), .AEMPTY_LEVEL(AEA))
    dut_a (.clk(clk), .rst(rst), .bus(bus_a));
  param_fifo #(.WIDTH(W), .DEPTH(DB), .FWFT(1), .AFULL_LEVEL(AFB), .AEMPTY_LEVEL(AEB))
    dut_b (.clk(clk), .rst(rst), .bus(bus_b));

  // Reference model: stored words as queues, plus scoreboards of expected read data.
  logic [W-1:0] q_a[$];
  logic [W-1:0] q_b[$];
  logic [W-1:0] sb_a[$];
  logic [W-1:0] sb_b[$];
  logic         ovf_a, unf_a, ovf_b, unf_b, vld_a;
  logic [W-1:0] dout_a_exp;
  int vectors    = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q_a.delete(); q_b.delete(); sb_a.delete(); sb_b.delete();
    ovf_a = 1'b0; unf_a = 1'b0; ovf_b = 1'b0; unf_b = 1'b0;
    vld_a = 1'b0; dout_a_exp = '0;
  endtask

  task automatic check_state_a();
    int n = q_a.size();
    check("a_count", 32'(bus_a.count), 32'(n));
    check("a_full", 32'(bus_a.full), 32'(n == DA));
    check("a_empty", 32'(bus_a.empty), 32'(n == 0));
    check("a_almost_full", 32'(bus_a.almost_full), 32'(n >= AFA));
    check("a_almost_empty", 32'(bus_a.almost_empty), 32'(n <= AEA));
    check("a_overflow", 32'(bus_a.overflow), 32'(ovf_a));
    check("a_underflow", 32'(bus_a.underflow), 32'(unf_a));
    check("a_dout_valid", 32'(bus_a.dout_valid), 32'(vld_a));
    if (!vld_a) check("a_dout_hold", 32'(bus_a.dout), 32'(dout_a_exp));
  endtask

  task automatic check_state_b();
    int n = q_b.size();
    check("b_count", 32'(bus_b.count), 32'(n));
    check("b_full", 32'(bus_b.full), 32'(n == DB));
    check("b_empty", 32'(bus_b.empty), 32'(n == 0));
    check("b_almost_full", 32'(bus_b.almost_full), 32'(n >= AFB));
    check("b_almost_empty", 32'(bus_b.almost_empty), 32'(n <= AEB));
    check("b_overflow", 32'(bus_b.overflow), 32'(ovf_b));
    check("b_underflow", 32'(bus_b.underflow), 32'(unf_b));
    check("b_dout_valid", 32'(bus_b.dout_valid), 32'(n > 0));
  endtask

  // Monitor: status against the model, data against the scoreboards.
  always @(negedge clk) begin
    check_state_a();
    check_state_b();
    if (bus_a.dout_valid) begin
      check("a_sb_pending", 32'(sb_a.size() != 0), 32'd1);
      if (sb_a.size() != 0) check("a_read_data", 32'(bus_a.dout), 32'(sb_a.pop_front()));
    end
    if (bus_b.dout_valid && bus_b.rd_en && !bus_b.flush) begin
      check("b_sb_pending", 32'(sb_b.size() != 0), 32'd1);
      if (sb_b.size() != 0) check("b_read_data", 32'(bus_b.dout), 32'(sb_b.pop_front()));
    end
  end

  // One clock of stimulus; called at posedge+1 and returns at the next posedge+1.
  task automatic step(input logic w, input logic [W-1:0] d, input logic r, input logic f);
    int   na = q_a.size();
    int   nb = q_b.size();
    logic wa = w && (na < DA) && !f;
    logic ra = r && (na > 0) && !f;
    logic wb = w && (nb < DB) && !f;
    logic rb = r && (nb > 0) && !f;
    bus_a.wr_en = w; bus_a.din = d; bus_a.rd_en = r; bus_a.flush = f;
    bus_b.wr_en = w; bus_b.din = d; bus_b.rd_en = r; bus_b.flush = f;
    if (ra) sb_a.push_back(q_a[0]);
    if (rb) sb_b.push_back(q_b[0]);
    @(posedge clk);
    #1;
    if (f) begin
      q_a.delete(); q_b.delete();
      ovf_a = 1'b0; unf_a = 1'b0; ovf_b = 1'b0; unf_b = 1'b0;
      vld_a = 1'b0; dout_a_exp = '0;
    end else begin
      if (w && na == DA) ovf_a = 1'b1;
      if (r && na == 0)  unf_a = 1'b1;
      if (w && nb == DB) ovf_b = 1'b1;
      if (r && nb == 0)  unf_b = 1'b1;
      vld_a = ra;
      if (ra) dout_a_exp = q_a.pop_front();
      if (wa) q_a.push_back(d);
      if (rb) void'(q_b.pop_front());
      if (wb) q_b.push_back(d);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic reset_mid();
    bus_a.wr_en = 1'b0; bus_a.rd_en = 1'b0; bus_a.flush = 1'b0;
    bus_b.wr_en = 1'b0; bus_b.rd_en = 1'b0; bus_b.flush = 1'b0;
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    check_state_a();
    check_state_b();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    model_reset();
    bus_a.wr_en = 1'b0; bus_a.rd_en = 1'b0; bus_a.flush = 1'b0; bus_a.din = '0;
    bus_b.wr_en = 1'b0; bus_b.rd_en = 1'b0; bus_b.flush = 1'b0; bus_b.din = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    idle(2);

    // Fill, overflow, drain, underflow; repeated so both pointers wrap.
    for (int rep = 0; rep < 3; rep++) begin
      for (int i = 1; i <= 5; i++) step(1'b1, W'(i), 1'b0, 1'b0);
      step(1'b1, 16'h00AA, 1'b0, 1'b0);
      for (int i = 0; i < 6; i++) step(1'b0, '0, 1'b1, 1'b0);
    end

    // Fall-through latency into an empty FIFO.
    step(1'b0, '0, 1'b0, 1'b1);
    step(1'b1, 16'h1234, 1'b0, 1'b0);
    check("b_fwft_first_word", 32'(bus_b.dout), 32'h1234);
    step(1'b0, '0, 1'b1, 1'b0);
    idle(1);

    // Simultaneous read/write at count=2, count=DEPTH and count=0.
    step(1'b0, '0, 1'b0, 1'b1);
    step(1'b1, 16'h0101, 1'b0, 1'b0);
    step(1'b1, 16'h0202, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b1, W'(16'h0300 + i), 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, W'(16'h0400 + i), 1'b0, 1'b0);
    step(1'b1, 16'h0555, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, '0, 1'b1, 1'b0);
    step(1'b1, 16'h0666, 1'b1, 1'b0);
    idle(1);

    // Almost flags: one word at a time from empty to eight and back.
    step(1'b0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) step(1'b1, W'(16'h0700 + i), 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) step(1'b0, '0, 1'b1, 1'b0);

    // Flush wins over a simultaneous write and read.
    step(1'b0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) step(1'b1, W'(16'h0800 + i), 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b1, 16'hDEAD, 1'b1, 1'b1);
    step(1'b1, 16'h0001, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    idle(1);

    // Asynchronous reset with three words stored.
    step(1'b0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b1, W'(16'h0900 + i), 1'b0, 1'b0);
    reset_mid();
    step(1'b1, 16'h0BEE, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    idle(1);

    // Random traffic, alternating write-heavy and read-heavy phases.
    for (int i = 0; i < 3000; i++) begin
      int   bias = ((i / 400) % 2 == 0) ? 70 : 30;
      logic w = ($urandom_range(99) < bias);
      logic r = ($urandom_range(99) < (100 - bias));
      logic f = ($urandom_range(63) == 0);
      step(w, W'($urandom), r, f);
    end

    idle(2);
    check("a_sb_drained", 32'(sb_a.size()), 32'd0);
    check("b_sb_drained", 32'(sb_b.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
